// File: rtl/plic.sv
// plic - platform-level interrupt arbiter.
//
// Latches level-triggered sources into per-source pending bits. Each source
// has an enable bit and a priority. The highest-priority eligible source is
// forwarded on int_flag_o when its priority exceeds THRESHOLD. Software uses
// a single-cycle register port to configure the block and to run
// claim/complete.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   src_i      level interrupt requests; bit i is source ID i+1
//   we_i/re_i  register write / read strobes
//   addr_i     byte offset (bits [1:0] ignored)
//   wdata_i    write data
//   rdata_o    registered read data
//   int_flag_o registered winning source ID, 0 when there is no request
module plic #(
  parameter int N_SRC = 8,
  parameter int PRI_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic [7:0]       int_flag_o
);

  localparam logic [5:0] W_PENDING   = 6'd0;
  localparam logic [5:0] W_ENABLE    = 6'd1;
  localparam logic [5:0] W_THRESHOLD = 6'd2;
  localparam logic [5:0] W_CLAIM     = 6'd3;

  // State is indexed by source ID (1..N_SRC).
  logic [N_SRC:1]   pending_reg;
  logic [N_SRC:1]   in_service_reg;
  logic [N_SRC:1]   enable_reg;
  logic [PRI_W-1:0] prio_reg [1:N_SRC];
  logic [PRI_W-1:0] thr_reg;
  logic [31:0]      rdata_reg;
  logic [7:0]       flag_reg;

  logic [5:0]       word;
  logic             claim;
  logic             claim_take;
  logic             complete;
  logic [7:0]       cmp_id;
  logic [N_SRC:1]   eligible;
  logic [7:0]       best_id;
  logic [PRI_W-1:0] best_pri;
  logic [7:0]       fwd_id;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign word      = addr_i[7:2];
  assign claim     = re_i && !we_i && (word == W_CLAIM);
  assign claim_take = claim && (fwd_id != 8'd0);
  assign complete  = we_i && (word == W_CLAIM);
  assign cmp_id    = wdata_i[7:0];
  assign unused_ok = ^{addr_i[1:0], wdata_i};

  generate
    for (genvar gi = 1; gi <= N_SRC; gi++) begin : g_elig
      assign eligible[gi] = pending_reg[gi] && enable_reg[gi] && (prio_reg[gi] != '0);
    end
  endgenerate

  // Strictly-greater compare while scanning upward makes the lowest ID win ties.
  always_comb begin
    best_id  = 8'd0;
    best_pri = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (eligible[k] && (prio_reg[k] > best_pri)) begin
        best_pri = prio_reg[k];
        best_id  = 8'(k);
      end
    end
    fwd_id = (best_pri > thr_reg) ? best_id : 8'd0;
  end

  always_comb begin
    rd_mux = 32'd0;
    case (word)
      W_PENDING:   rd_mux = 32'({pending_reg, 1'b0});
      W_ENABLE:    rd_mux = 32'({enable_reg, 1'b0});
      W_THRESHOLD: rd_mux = 32'(thr_reg);
      W_CLAIM:     rd_mux = 32'(fwd_id);
      default: begin
        for (int k = 1; k <= N_SRC; k++) begin
          if (int'(word) == 4 + k) rd_mux = 32'(prio_reg[k]);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg    <= '0;
      in_service_reg <= '0;
      enable_reg     <= '0;
      thr_reg        <= '0;
      rdata_reg      <= 32'd0;
      flag_reg       <= 8'd0;
      for (int k = 1; k <= N_SRC; k++) prio_reg[k] <= '0;
    end else begin
      for (int k = 1; k <= N_SRC; k++) begin
        if (claim_take && (int'(fwd_id) == k)) begin
          pending_reg[k]    <= 1'b0;
          in_service_reg[k] <= 1'b1;
        end else begin
          // Gateway: a source already being serviced cannot re-pend.
          pending_reg[k] <= pending_reg[k] | (src_i[k-1] & ~in_service_reg[k]);
          if (complete && (int'(cmp_id) == k)) in_service_reg[k] <= 1'b0;
        end
        if (we_i && (int'(word) == 4 + k)) prio_reg[k] <= wdata_i[PRI_W-1:0];
      end

      if (we_i && (word == W_ENABLE))    enable_reg <= wdata_i[N_SRC:1];
      if (we_i && (word == W_THRESHOLD)) thr_reg    <= wdata_i[PRI_W-1:0];

      // A read colliding with a write is suppressed and returns 0.
      if (re_i && we_i) rdata_reg <= 32'd0;
      else if (re_i)    rdata_reg <= rd_mux;

      // Force a gap cycle after a claim so the claimed ID is not re-signalled.
      flag_reg <= claim_take ? 8'd0 : fwd_id;
    end
  end

  assign rdata_o    = rdata_reg;
  assign int_flag_o = flag_reg;

endmodule

// File: tb/tb_plic.sv
module tb_plic;

  localparam int N_SRC = 8;
  localparam int PRI_W = 3;

  logic             clk;
  logic             rst_n;
  logic [N_SRC-1:0] src;
  logic             we;
  logic             re;
  logic [7:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [7:0]       int_flag;

  plic #(.N_SRC(N_SRC), .PRI_W(PRI_W)) dut (
    .clk(clk), .rst_n(rst_n), .src_i(src), .we_i(we), .re_i(re),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .int_flag_o(int_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock cycle: inputs held for the cycle, outputs expected
  // after its rising edge.
  typedef struct {
    logic        rst;
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  src;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [7:0]  exp_flag;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic r, logic w, logic rd, logic [7:0] a, logic [31:0] d,
                              logic [7:0] s, logic c, logic [31:0] er, logic [7:0] ef);
    vec_t v;
    v.rst = r; v.we = w; v.re = rd; v.addr = a; v.wdata = d; v.src = s;
    v.chk_rd = c; v.exp_rd = er; v.exp_flag = ef;
    return v;
  endfunction

  function automatic vec_t rd_v(logic [7:0] a, logic [7:0] s, logic [31:0] er, logic [7:0] ef);
    return mk(1'b0, 1'b0, 1'b1, a, 32'd0, s, 1'b1, er, ef);
  endfunction

  function automatic vec_t wr_v(logic [7:0] a, logic [31:0] d, logic [7:0] s, logic [7:0] ef);
    return mk(1'b0, 1'b1, 1'b0, a, d, s, 1'b0, 32'd0, ef);
  endfunction

  function automatic vec_t idle_v(logic [7:0] s, logic [7:0] ef);
    return mk(1'b0, 1'b0, 1'b0, 8'h00, 32'd0, s, 1'b0, 32'd0, ef);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; src = '0; we = 1'b0; re = 1'b0; addr = 8'h00; wdata = 32'd0;

    // Reset state, then a source raised while everything is disabled.
    vecs.push_back(rd_v(8'h00, 8'h00, 32'h0, 8'd0));
    vecs.push_back(rd_v(8'h04, 8'h00, 32'h0, 8'd0));
    vecs.push_back(rd_v(8'h08, 8'h00, 32'h0, 8'd0));
    vecs.push_back(rd_v(8'h14, 8'h00, 32'h0, 8'd0));
    vecs.push_back(rd_v(8'h0C, 8'h00, 32'h0, 8'd0));
    vecs.push_back(idle_v(8'h04, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h04, 32'h8, 8'd0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 32'd0, 8'h00, 1'b1, 32'h0, 8'd0));
    // Configure: IDs 2 and 3 enabled, both priority 3, threshold 0.
    vecs.push_back(wr_v(8'h04, 32'h0C, 8'h00, 8'd0));
    vecs.push_back(wr_v(8'h18, 32'h3, 8'h00, 8'd0));
    vecs.push_back(wr_v(8'h1C, 32'h3, 8'h00, 8'd0));
    vecs.push_back(wr_v(8'h08, 32'h0, 8'h00, 8'd0));
    vecs.push_back(rd_v(8'h04, 8'h00, 32'h0C, 8'd0));
    vecs.push_back(rd_v(8'h18, 8'h00, 32'h3, 8'd0));
    // Tie between IDs 2 and 3: flag two edges after the request.
    vecs.push_back(idle_v(8'h06, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd2));
    // Claim 2, then 3.
    vecs.push_back(rd_v(8'h0C, 8'h06, 32'd2, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h08, 8'd3));
    vecs.push_back(rd_v(8'h0C, 8'h06, 32'd3, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h0, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd0));
    // Complete 2 with the source still high: re-pends, then forwarded.
    vecs.push_back(wr_v(8'h0C, 32'd2, 8'h06, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h04, 8'd2));
    vecs.push_back(wr_v(8'h0C, 32'd0, 8'h06, 8'd2));
    vecs.push_back(wr_v(8'h0C, 32'd9, 8'h06, 8'd2));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h04, 8'd2));
    // Threshold masks, priority raise restores, threshold masks again.
    vecs.push_back(wr_v(8'h08, 32'd3, 8'h06, 8'd2));
    vecs.push_back(idle_v(8'h06, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h04, 8'd0));
    vecs.push_back(wr_v(8'h18, 32'd4, 8'h06, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd2));
    vecs.push_back(wr_v(8'h08, 32'd4, 8'h06, 8'd2));
    vecs.push_back(idle_v(8'h06, 8'd0));
    vecs.push_back(rd_v(8'h0C, 8'h06, 32'd0, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h04, 8'd0));
    // Disable keeps pending; re-enable forwards again.
    vecs.push_back(wr_v(8'h08, 32'd0, 8'h06, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd2));
    vecs.push_back(wr_v(8'h04, 32'h08, 8'h06, 8'd2));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h04, 8'd0));
    vecs.push_back(wr_v(8'h04, 32'h0C, 8'h06, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd2));
    // Simultaneous write and read: read suppressed, rdata 0.
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'h04, 32'h0C, 8'h06, 1'b1, 32'h0, 8'd2));
    vecs.push_back(rd_v(8'h04, 8'h06, 32'h0C, 8'd2));
    // Unmapped offsets and the last priority register.
    vecs.push_back(wr_v(8'h10, 32'hFF, 8'h06, 8'd2));
    vecs.push_back(rd_v(8'h10, 8'h06, 32'h0, 8'd2));
    vecs.push_back(rd_v(8'h40, 8'h06, 32'h0, 8'd2));
    vecs.push_back(wr_v(8'h30, 32'd7, 8'h06, 8'd2));
    vecs.push_back(rd_v(8'h30, 8'h06, 32'd7, 8'd2));
    // Reset with ID 3 in service and ID 2 pending; then re-pend and re-enable.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 32'd0, 8'h06, 1'b1, 32'h0, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd0));
    vecs.push_back(rd_v(8'h00, 8'h06, 32'h0C, 8'd0));
    vecs.push_back(rd_v(8'h04, 8'h06, 32'h0, 8'd0));
    vecs.push_back(rd_v(8'h18, 8'h06, 32'h0, 8'd0));
    vecs.push_back(wr_v(8'h04, 32'h04, 8'h06, 8'd0));
    vecs.push_back(wr_v(8'h18, 32'd1, 8'h06, 8'd0));
    vecs.push_back(idle_v(8'h06, 8'd2));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = ~vecs[i].rst;
      we    = vecs[i].we;
      re    = vecs[i].re;
      addr  = vecs[i].addr;
      wdata = vecs[i].wdata;
      src   = vecs[i].src;
      @(negedge clk);
      $display("row %0d rst=%0b we=%0b re=%0b addr=%02h wdata=%0h src=%02h -> rdata=%0h int_flag=%0d",
               i, vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata,
               vecs[i].src, rdata, int_flag);
      check($sformatf("row%0d int_flag", i), 32'(int_flag), 32'(vecs[i].exp_flag));
      if (vecs[i].chk_rd) check($sformatf("row%0d rdata", i), rdata, vecs[i].exp_rd);
    end
    rst_n = 1'b1; we = 1'b0; re = 1'b0;

    // Reset acts without a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: int_flag=%0d rdata=%0h", int_flag, rdata);
    check("async_rst int_flag", 32'(int_flag), 32'd0);
    check("async_rst rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Re-enable after reset and measure the bounded forwarding latency.
    we = 1'b1; addr = 8'h04; wdata = 32'h04;
    @(negedge clk);
    addr = 8'h18; wdata = 32'd2;
    @(negedge clk);
    we = 1'b0;
    cyc = 0;
    while (int_flag == 8'd0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    $display("re-enable: int_flag=%0d after %0d cycles", int_flag, cyc);
    check("reenable int_flag", 32'(int_flag), 32'd2);
    check("reenable latency", 32'(cyc), 32'd1);

    // Claim then confirm the one-cycle gap and no re-signal while in service.
    re = 1'b1; addr = 8'h0C;
    @(negedge clk);
    re = 1'b0;
    $display("claim: rdata=%0d int_flag=%0d", rdata, int_flag);
    check("claim2 rdata", rdata, 32'd2);
    check("claim2 gap", 32'(int_flag), 32'd0);
    repeat (3) @(negedge clk);
    $display("in service: int_flag=%0d", int_flag);
    check("in_service quiet", 32'(int_flag), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
